// File: rtl/shift_rx_deser.sv
// shift_rx_deser: serial-to-parallel receiver, LSB first, with a single-entry
// valid/ready output register.
//
// Optional feature macro: SHIFT_RX_PARITY_EN
//   defined   - each frame is WIDTH data bits plus one even-parity bit;
//               parity_err is registered alongside out_data
//   undefined - each frame is WIDTH data bits; parity_err is tied to 0
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-high; clears all state
//   ser_in     - serial data bit
//   ser_valid  - ser_in is sampled on this edge when high
//   frame_clr  - synchronous; drops the partial word, bit counter to 0
//   out_data   - assembled word, bit 0 is the first bit received
//   out_valid  - out_data holds an unconsumed word
//   out_ready  - consumer accepts the word when out_valid is also high
//   parity_err - parity status of the held word
//   overflow   - sticky; a completed word was dropped (output full)
//   busy       - a partial frame is in progress
module shift_rx_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

`ifdef SHIFT_RX_PARITY_EN
  typedef enum logic {S_DATA, S_PAR} state_t;
`else
  typedef enum logic {S_DATA} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] commit_data;
  logic             commit;
  logic             load;
`ifdef SHIFT_RX_PARITY_EN
  logic             commit_perr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_DATA;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    commit      = 1'b0;
    commit_data = sr;
`ifdef SHIFT_RX_PARITY_EN
    commit_perr = 1'b0;
`endif
    if (frame_clr) begin
      // frame_clr wins over a bit strobed in the same cycle
      cnt_n   = '0;
      state_n = S_DATA;
    end else if (ser_valid) begin
      case (state)
        S_DATA: begin
          sr_n = {ser_in, sr[WIDTH-1:1]};
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
`ifdef SHIFT_RX_PARITY_EN
            state_n = S_PAR;
`else
            commit      = 1'b1;
            commit_data = sr_n;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`ifdef SHIFT_RX_PARITY_EN
        S_PAR: begin
          // sr already holds the full word; the parity bit is not shifted in
          commit      = 1'b1;
          commit_perr = ^{sr, ser_in};
          state_n     = S_DATA;
        end
`endif
        default: ;
      endcase
    end
  end

  // A commit loads when the register is empty or is being popped this cycle,
  // so back-to-back words never bubble.
  assign load = commit && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      out_data  <= commit_data;
      out_valid <= 1'b1;
    end else begin
      if (commit) overflow <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef SHIFT_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= commit_perr;
    end
  end

  assign busy = (cnt != '0) || (state == S_PAR);
`else
  assign parity_err = 1'b0;
  assign busy       = (cnt != '0);
`endif

endmodule

// File: tb/tb_shift_rx_deser.sv
// tb_shift_rx_deser: self-checking bench for shift_rx_deser (WIDTH=8).
// Accepted words are queued when their final bit is driven and compared
// when the consumer handshake takes them.
module tb_shift_rx_deser;

`ifdef SHIFT_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_in;
  logic       ser_valid;
  logic       frame_clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       parity_err;
  logic       overflow;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [8:0] sb[$];   // {parity_err, data}

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       exp_perr;   // expected when parity is enabled
  } vec_t;

  vec_t vecs[8];

  shift_rx_deser #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .frame_clr  (frame_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer side: a word is taken on the next edge when valid && ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no word", out_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("sb_data", {8'h0, out_data}, {8'h0, e[7:0]});
        check("sb_perr", {15'h0, parity_err}, {15'h0, e[8]});
      end
    end
  end

  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic p, input logic acc, input logic ep);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(p);
    if (acc) sb.push_back({ep, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a5;
    vecs[0] = '{8'h01, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 1'b1};

    reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; frame_clr = 1'b0; out_ready = 1'b0;
    idle(2);
    check("rst_data",  {8'h0, out_data},   16'h0);
    check("rst_valid", {15'h0, out_valid}, 16'h0);
    check("rst_perr",  {15'h0, parity_err},16'h0);
    check("rst_ovf",   {15'h0, overflow},  16'h0);
    check("rst_busy",  {15'h0, busy},      16'h0);
    reset = 1'b0;
    idle(1);

    // 0xA5 LSB first, with busy tracked per bit
    out_ready = 1'b1;
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send_bit(a5[i]);
      if (i < 7) check("a5_busy", {15'h0, busy}, 16'h1);
    end
    check("a5_busy_last", {15'h0, busy}, {15'h0, PAR_EN});
    if (PAR_EN) send_bit(1'b0);
    check("a5_busy_end", {15'h0, busy},      16'h0);
    check("a5_valid",    {15'h0, out_valid}, 16'h1);
    check("a5_data",     {8'h0, out_data},   16'h00A5);
    check("a5_ovf",      {15'h0, overflow},  16'h0);
    sb.push_back({1'b0, 8'hA5});
    idle(1);

    // table-driven back-to-back words with the consumer always ready
    for (int v = 0; v < 8; v++)
      send_word(vecs[v].data, vecs[v].par_bit, 1'b1, PAR_EN ? vecs[v].exp_perr : 1'b0);
    idle(2);
    check("b2b_ovf",    {15'h0, overflow}, 16'h0);
    check("b2b_drain",  16'(sb.size()),    16'h0);

    // overflow: second word dropped while the first is unconsumed
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    check("ovf_valid", {15'h0, out_valid}, 16'h1);
    check("ovf_data",  {8'h0, out_data},   16'h003C);
    check("ovf_flag",  {15'h0, overflow},  16'h1);
    idle(3);
    check("ovf_hold",  {8'h0, out_data},   16'h003C);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("ovf_pop_valid", {15'h0, out_valid}, 16'h0);
    check("ovf_sticky",    {15'h0, overflow},  16'h1);
    check("ovf_drain",     16'(sb.size()),     16'h0);

    // frame_clr with a simultaneous bit discards the partial word
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("fc_busy_pre", {15'h0, busy}, 16'h1);
    frame_clr = 1'b1;
    send_bit(1'b1);
    frame_clr = 1'b0;
    check("fc_busy_post", {15'h0, busy}, 16'h0);
    send_word(8'hC3, 1'b0, 1'b1, 1'b0);
    check("fc_data",  {8'h0, out_data},   16'h00C3);
    check("fc_valid", {15'h0, out_valid}, 16'h1);
    idle(1);

    // reset mid-word with a held, unconsumed word
    out_ready = 1'b0;
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("pre_rst_valid", {15'h0, out_valid}, 16'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_data",  {8'h0, out_data},    16'h0);
    check("arst_valid", {15'h0, out_valid},  16'h0);
    check("arst_perr",  {15'h0, parity_err}, 16'h0);
    check("arst_ovf",   {15'h0, overflow},   16'h0);
    check("arst_busy",  {15'h0, busy},       16'h0);
    sb.delete();
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'h0F, 1'b0, 1'b1, 1'b0);
    check("post_rst_data",  {8'h0, out_data},   16'h000F);
    check("post_rst_valid", {15'h0, out_valid}, 16'h1);
    idle(2);
    check("final_drain", 16'(sb.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
